// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and constants
package pipeline_pkg;
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTN        = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of {pc, instn} between fetch and decode
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign head_data = mem[rd_ptr[AW-1:0]];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, imem handshake, fetch queue, redirect
// Optional perf counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instn,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes
`endif
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int QW = ADDR_W + 32;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              run;
  logic              accept;
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic [QW-1:0]     q_head;

  // run holds requests off for the cycle in which reset is released.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    push      = 1'b0;
    case (state)
      FETCH: begin
        imem_req = run && (q_count < CW'(QUEUE_DEPTH)) && !redirect_valid;
        if (imem_req && imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = FETCH;
          push      = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign accept    = imem_req && imem_ready;
  assign pop       = !q_empty && !id_stall && !redirect_valid;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      run    <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (redirect_valid) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (accept) begin
        pc     <= pc + ADDR_W'(4);
        req_pc <= pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (QW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push && (!q_full || pop)),
    .push_data ({req_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign if_id_valid    = !q_empty;
  assign if_id_instn    = q_empty ? NOP_INSTN : q_head[31:0];
  assign if_id_pc       = q_empty ? '0 : q_head[QW-1:32];
  assign if_id_pc_plus4 = if_id_pc + ADDR_W'(4);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 1'b1;
      if (redirect_valid && perf_flushes != 32'hFFFF_FFFF) perf_flushes <= perf_flushes + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a queue-level model
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_instn;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_id_valid    (if_id_valid),
    .if_id_instn    (if_id_instn),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Model: the instruction stream is sequential from the last redirect target;
  // the queue holds PCs of returned, non-stale fetches.
  logic [31:0] q_pc[$];
  logic [31:0] fetch_pc = '0;
  logic [31:0] out_addr = '0;
  bit          outstanding = 0;
  bit          stale = 0;
  bit          stray = 0;
  int          wait_cnt = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  logic [31:0] m_fetched = '0;
  logic [31:0] m_flushes = '0;

  task automatic cycle(input bit stall, input bit ready, input bit redir, input logic [31:0] tgt);
    bit rv;
    bit exp_req;
    @(negedge clk);
    id_stall       = stall;
    imem_ready     = ready;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rv             = (outstanding && wait_cnt == 0) || (stray && !outstanding);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(outstanding ? out_addr : 32'hDEAD_0000) : $urandom;
    #1;
    exp_req = !outstanding && (q_pc.size() < DEPTH) && !redir;
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, fetch_pc);
    check_eq("if_id_valid", if_id_valid, q_pc.size() != 0);
    if (q_pc.size() != 0) begin
      check_eq("if_id_pc", if_id_pc, q_pc[0]);
      check_eq("if_id_instn", if_id_instn, mem_word(q_pc[0]));
      check_eq("if_id_pc_plus4", if_id_pc_plus4, q_pc[0] + 32'd4);
    end
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetched", perf_fetched, m_fetched);
    check_eq("perf_flushes", perf_flushes, m_flushes);
`endif
    if (redir) begin
      if (outstanding && !rv) stale = 1;
      q_pc.delete();
      fetch_pc = {tgt[31:2], 2'b00};
      if (m_flushes != 32'hFFFF_FFFF) m_flushes++;
    end else begin
      if (q_pc.size() != 0 && !stall) begin
        void'(q_pc.pop_front());
        if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
      end
      if (rv && outstanding && !stale) q_pc.push_back(out_addr);
    end
    if (rv && outstanding) begin
      outstanding = 0;
      stale = 0;
    end else if (outstanding) begin
      wait_cnt--;
    end
    if (exp_req && ready) begin
      outstanding = 1;
      out_addr = fetch_pc;
      fetch_pc = fetch_pc + 32'd4;
      wait_cnt = $urandom_range(lat_max, lat_min);
    end
    stray = 0;
  endtask

  task automatic apply_reset(input bit stray_after);
    @(negedge clk);
    reset = 1'b1;
    id_stall = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
    #1;
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_imem_addr", imem_addr, 32'h0);
    check_eq("rst_if_id_valid", if_id_valid, 1'b0);
    check_eq("rst_if_id_instn", if_id_instn, 32'h0);
    check_eq("rst_if_id_pc", if_id_pc, 32'h0);
    check_eq("rst_if_id_pc_plus4", if_id_pc_plus4, 32'h4);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_perf_fetched", perf_fetched, 32'h0);
    check_eq("rst_perf_flushes", perf_flushes, 32'h0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q_pc.delete();
    fetch_pc = 32'h0;
    outstanding = 0;
    stale = 0;
    m_fetched = '0;
    m_flushes = '0;
    stray = stray_after;
  endtask

  initial begin
    apply_reset(0);

    // Back-to-back fetch with one-cycle memory, no stall.
    lat_min = 0; lat_max = 0;
    repeat (10) cycle(0, 1, 0, 0);

    // Long decode stall fills the queue, then drains in order.
    repeat (10) cycle(1, 1, 0, 0);
    check_eq("stall_full", q_pc.size(), DEPTH);
    repeat (8) cycle(0, 1, 0, 0);

    // Redirect while a request is outstanding.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && !(outstanding && wait_cnt > 0); i++) cycle(0, 1, 0, 0);
    check_eq("wait_outstanding", outstanding, 1'b1);
    cycle(0, 1, 1, 32'h0000_0103);
    check_eq("redir_target", fetch_pc, 32'h0000_0100);
    repeat (8) cycle(0, 1, 0, 0);

    // Redirect coincident with a returning response.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 20 && !(outstanding && wait_cnt == 0); i++) cycle(0, 1, 0, 0);
    check_eq("wait_rvalid", outstanding, 1'b1);
    cycle(0, 1, 1, 32'h0000_0200);
    repeat (4) cycle(0, 1, 0, 0);

    // Redirect while the queue is full and decode is popping.
    for (int i = 0; i < 20 && q_pc.size() < DEPTH; i++) cycle(1, 1, 0, 0);
    check_eq("wait_full", q_pc.size(), DEPTH);
    cycle(0, 1, 1, 32'h0000_0300);
    repeat (4) cycle(0, 1, 0, 0);

    // Memory not ready, PC wraps past the top of the address space.
    cycle(0, 1, 1, 32'hFFFF_FFF8);
    repeat (5) cycle(0, 0, 0, 0);
    repeat (10) cycle(0, 1, 0, 0);

    // Reset while waiting; the late response must be ignored.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !outstanding; i++) cycle(0, 1, 0, 0);
    check_eq("wait_req_rst", outstanding, 1'b1);
    apply_reset(1);
    cycle(0, 0, 0, 0);
    repeat (6) cycle(0, 1, 0, 0);

    // Randomized traffic with occasional resets.
    lat_min = 0; lat_max = 3;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      if (n % 1000 == 999) apply_reset($urandom_range(1, 0) == 1);
      cycle($urandom_range(3, 0) == 0, $urandom_range(2, 0) != 0, $urandom_range(15, 0) == 0, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
